// File: rtl/sysmon_frame_formatter.sv
// rtl/sysmon_frame_formatter.sv - snapshots one monitor channel and serialises it as a SYNC/ADDR/DATA/CHECKSUM byte frame
module sysmon_frame_formatter #(
    parameter int         NUM_CH    = 8,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [6:0]               tx_address,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     tx_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    output logic                     frame_busy,
    output logic                     write_done,
    output logic                     write_dropped
);

    localparam int NB = DATA_W / 8;
    localparam int FL = 3 + NB;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [2:0]        idx;
    logic [6:0]        addr_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        csum;

    logic              req_err;
    logic [DATA_W-1:0] req_data;
    logic              accept;
    logic              last;
    logic [2:0]        nidx;
    logic [7:0]        next_csum;
    logic [7:0]        next_byte;

    // Out-of-range addresses match no channel, so their snapshot is zero.
    always_comb begin
        req_err  = ({25'd0, tx_address} >= 32'(NUM_CH));
        req_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tx_address == 7'(i)) begin
                req_data = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept = tx_valid & tx_ready;
    assign last   = (idx == 3'(FL - 1));
    assign nidx   = idx + 3'd1;

    // The checksum folds in each byte as it is accepted; SYNC (index 0) is skipped.
    always_comb begin
        next_csum = (idx == 3'd0) ? 8'h00 : (csum ^ tx_byte);
        next_byte = next_csum;
        if (nidx == 3'd1) begin
            next_byte = {err_q, addr_q};
        end
        for (int k = 0; k < NB; k++) begin
            if (nidx == 3'(k + 2)) begin
                next_byte = data_q[DATA_W-1-8*k -: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            addr_q        <= '0;
            err_q         <= 1'b0;
            data_q        <= '0;
            csum          <= '0;
            tx_byte       <= '0;
            tx_valid      <= 1'b0;
            frame_busy    <= 1'b0;
            write_done    <= 1'b0;
            write_dropped <= 1'b0;
        end else begin
            write_done    <= 1'b0;
            write_dropped <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (write) begin
                        addr_q     <= tx_address;
                        err_q      <= req_err;
                        data_q     <= req_data;
                        idx        <= '0;
                        csum       <= '0;
                        tx_byte    <= SYNC_BYTE;
                        tx_valid   <= 1'b1;
                        frame_busy <= 1'b1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    write_dropped <= write;
                    if (accept) begin
                        csum <= next_csum;
                        if (last) begin
                            tx_valid   <= 1'b0;
                            frame_busy <= 1'b0;
                            write_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            idx     <= nidx;
                            tx_byte <= next_byte;
                        end
                    end
                end
                S_DONE: begin
                    write_dropped <= write;
                    state         <= S_IDLE;
                end
                default: begin
                    tx_valid   <= 1'b0;
                    frame_busy <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
